// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the PC / branch controller
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // funct3 010/011 are not branch encodings; such instructions fall through
    function automatic logic funct3_legal(input logic [2:0] funct3);
        case (funct3)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: funct3_legal = 1'b1;
            default:                        funct3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// rtl/branch_pc_ctrl.sv - PC register, next-PC selection, flush window and branch statistics
module branch_pc_ctrl
    import branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               instr_valid_i,
    input  logic               is_branch_i,
    input  logic               is_jal_i,
    input  logic               is_jalr_i,
    input  logic [2:0]         funct3_i,
    input  logic [31:0]        rs1_data_i,
    input  logic [31:0]        rs2_data_i,
    input  logic [31:0]        imm_i,
    output logic [31:0]        cmp_operand_a_o,
    output logic [31:0]        cmp_operand_b_o,
    output logic [2:0]         cmp_operation_o,
    input  logic               cmp_result_i,
    output logic [31:0]        pc_o,
    output logic               flush_o,
    output logic               misalign_o,
    output logic [COUNT_W-1:0] branch_count_o,
    output logic [COUNT_W-1:0] taken_count_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        mis_q, mis_d;
    logic        flush_q;

    logic [31:0] target;
    logic        taken;
    logic        count_branch;
    logic        count_taken;

    assign cmp_operand_a_o = rs1_data_i;
    assign cmp_operand_b_o = rs2_data_i;
    assign cmp_operation_o = funct3_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fcnt_d       = fcnt_q;
        mis_d        = mis_q;
        target       = '0;
        taken        = 1'b0;
        count_branch = 1'b0;
        count_taken  = 1'b0;

        case (state_q)
            RUN: begin
                if (instr_valid_i) begin
                    if (is_jal_i) begin
                        target = pc_q + imm_i;
                        taken  = 1'b1;
                    end else if (is_jalr_i) begin
                        target = (rs1_data_i + imm_i) & ~32'h1;
                        taken  = 1'b1;
                    end else if (is_branch_i && funct3_legal(funct3_i)) begin
                        target       = pc_q + imm_i;
                        taken        = cmp_result_i;
                        count_branch = 1'b1;
                    end

                    // a misaligned redirect freezes the PC at the offending instruction
                    if (taken) begin
                        if (target[1:0] != 2'b00) begin
                            mis_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d        = target;
                            count_taken = 1'b1;
                            if (FLUSH_CYCLES > 0) begin
                                state_d = FLUSH;
                                fcnt_d  = FLUSH_LOAD;
                            end
                        end
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end

            FLUSH: begin
                pc_d   = pc_q + PC_STEP;
                fcnt_d = fcnt_q - 3'd1;
                if (fcnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fcnt_q  <= '0;
            mis_q   <= 1'b0;
            flush_q <= 1'b0;
        end else if (!stall_i) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            mis_q   <= mis_d;
            flush_q <= (state_d != RUN);
        end
    end

    sat_counter #(.W(COUNT_W)) u_branch_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count_branch),
        .en    (!stall_i),
        .count (branch_count_o)
    );

    sat_counter #(.W(COUNT_W)) u_taken_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count_taken),
        .en    (!stall_i),
        .count (taken_count_o)
    );

    assign pc_o       = pc_q;
    assign flush_o    = flush_q;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb/tb_branch_pc_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_branch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        instr_valid_i;
    logic        is_branch_i;
    logic        is_jal_i;
    logic        is_jalr_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic        cmp_result_i;

    logic [31:0] opa_a, opb_a, opa_b, opb_b, opa_c, opb_c;
    logic [2:0]  op_a, op_b, op_c;
    logic [31:0] pc_a, pc_b, pc_c;
    logic        fl_a, fl_b, fl_c, mis_a, mis_b, mis_c;
    logic [15:0] bc_a, tc_a;
    logic [1:0]  bc_b, tc_b;
    logic [3:0]  bc_c, tc_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_pc_ctrl #(.RESET_PC(32'h100), .FLUSH_CYCLES(1), .COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .instr_valid_i(instr_valid_i),
        .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .cmp_operand_a_o(opa_a), .cmp_operand_b_o(opb_a), .cmp_operation_o(op_a),
        .cmp_result_i(cmp_result_i), .pc_o(pc_a), .flush_o(fl_a), .misalign_o(mis_a),
        .branch_count_o(bc_a), .taken_count_o(tc_a));

    branch_pc_ctrl #(.RESET_PC(32'h100), .FLUSH_CYCLES(0), .COUNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .instr_valid_i(instr_valid_i),
        .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .cmp_operand_a_o(opa_b), .cmp_operand_b_o(opb_b), .cmp_operation_o(op_b),
        .cmp_result_i(cmp_result_i), .pc_o(pc_b), .flush_o(fl_b), .misalign_o(mis_b),
        .branch_count_o(bc_b), .taken_count_o(tc_b));

    branch_pc_ctrl #(.RESET_PC(32'h100), .FLUSH_CYCLES(3), .COUNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .instr_valid_i(instr_valid_i),
        .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .cmp_operand_a_o(opa_c), .cmp_operand_b_o(opb_c), .cmp_operation_o(op_c),
        .cmp_result_i(cmp_result_i), .pc_o(pc_c), .flush_o(fl_c), .misalign_o(mis_c),
        .branch_count_o(bc_c), .taken_count_o(tc_c));

    // reference model: one entry per instance; mode 0 = running, 1 = flushing, 2 = halted
    int          P_FC[3] = '{1, 0, 3};
    int          P_W[3]  = '{16, 2, 4};
    logic [31:0] m_pc[3];
    int          m_mode[3];
    int          m_left[3];
    int          m_bc[3];
    int          m_tc[3];
    logic        m_mis[3];

    function automatic int bump(int v, int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    function automatic void model_step(int k);
        logic [31:0] tgt;
        logic        jump;
        tgt  = '0;
        jump = 1'b0;
        if (!rst_n) begin
            m_pc[k] = 32'h100; m_mode[k] = 0; m_left[k] = 0;
            m_bc[k] = 0; m_tc[k] = 0; m_mis[k] = 1'b0;
        end else if (stall_i) begin
            // frozen
        end else if (m_mode[k] == 1) begin
            m_pc[k]   = m_pc[k] + 32'd4;
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) m_mode[k] = 0;
        end else if (m_mode[k] == 0 && instr_valid_i) begin
            if (is_jal_i) begin
                tgt = m_pc[k] + imm_i; jump = 1'b1;
            end else if (is_jalr_i) begin
                tgt = rs1_data_i + imm_i; tgt[0] = 1'b0; jump = 1'b1;
            end else if (is_branch_i && funct3_i != 3'd2 && funct3_i != 3'd3) begin
                m_bc[k] = bump(m_bc[k], P_W[k]);
                tgt = m_pc[k] + imm_i; jump = cmp_result_i;
            end
            if (!jump) begin
                m_pc[k] = m_pc[k] + 32'd4;
            end else if (tgt % 4 != 0) begin
                m_mis[k] = 1'b1; m_mode[k] = 2;
            end else begin
                m_pc[k] = tgt;
                m_tc[k] = bump(m_tc[k], P_W[k]);
                if (P_FC[k] > 0) begin
                    m_mode[k] = 1; m_left[k] = P_FC[k];
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input int k, input logic [31:0] pc, input logic fl, input logic mis,
                             input logic [31:0] bc, input logic [31:0] tc);
        string t;
        t = $sformatf("dut%0d", k);
        chk({t, "_pc"},    pc,  m_pc[k]);
        chk({t, "_flush"}, 32'(fl),  32'(m_mode[k] != 0));
        chk({t, "_mis"},   32'(mis), 32'(m_mis[k]));
        chk({t, "_bc"},    bc,  32'(m_bc[k]));
        chk({t, "_tc"},    tc,  32'(m_tc[k]));
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        chk_model(0, pc_a, fl_a, mis_a, 32'(bc_a), 32'(tc_a));
        chk_model(1, pc_b, fl_b, mis_b, 32'(bc_b), 32'(tc_b));
        chk_model(2, pc_c, fl_c, mis_c, 32'(bc_c), 32'(tc_c));
        chk("pass_a", opa_a, rs1_data_i);
        chk("pass_b", opb_a, rs2_data_i);
        chk("pass_op", 32'(op_a), 32'(funct3_i));
    endtask

    task automatic drive(input logic rn, input logic st, input logic v, input logic br,
                         input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic cmp);
        rst_n = rn; stall_i = st; instr_valid_i = v; is_branch_i = br; is_jal_i = jal;
        is_jalr_i = jalr; funct3_i = f3; rs1_data_i = rs1; rs2_data_i = rs2;
        imm_i = imm; cmp_result_i = cmp;
    endtask

    typedef struct {
        logic        rn, st, v, br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, imm;
        logic        cmp;
        logic [31:0] e_pc;
        logic        e_fl, e_mis;
        int          e_bc, e_tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rn, logic st, logic v, logic br, logic jal, logic jalr,
                                logic [2:0] f3, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic cmp, logic [31:0] e_pc,
                                logic e_fl, logic e_mis, int e_bc, int e_tc);
        vec_t r;
        r.rn = rn; r.st = st; r.v = v; r.br = br; r.jal = jal; r.jalr = jalr; r.f3 = f3;
        r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.cmp = cmp;
        r.e_pc = e_pc; r.e_fl = e_fl; r.e_mis = e_mis; r.e_bc = e_bc; r.e_tc = e_tc;
        return r;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        // expectations below are for dut_a: RESET_PC=0x100, FLUSH_CYCLES=1
        tbl.push_back(mk(0,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h100, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h104, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h108, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h10C, 0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h100, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,1,0,0, 3'd0, 32'hABCDEFFF, 32'hABCDEFFF, 32'h20, 1, 32'h120, 1,0, 1,1));
        tbl.push_back(mk(1,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h124, 0,0, 1,1));
        tbl.push_back(mk(1,0,1,1,0,0, 3'd4, 32'hABCDEF01, 32'h12345678, 32'h40, 0, 32'h128, 0,0, 2,1));
        tbl.push_back(mk(1,0,0,1,1,0, 3'd0, 0, 0, 32'h40, 1,                 32'h128, 0,0, 2,1));
        tbl.push_back(mk(1,0,1,1,0,0, 3'd2, 0, 0, 32'h40, 1,                 32'h12C, 0,0, 2,1));
        tbl.push_back(mk(1,0,1,1,0,0, 3'd1, 1, 2, 32'h10, 1,                 32'h13C, 1,0, 3,2));
        tbl.push_back(mk(1,1,1,0,1,0, 3'd0, 0, 0, 32'h80, 0,                 32'h13C, 1,0, 3,2));
        tbl.push_back(mk(1,1,1,0,1,0, 3'd0, 0, 0, 32'h80, 0,                 32'h13C, 1,0, 3,2));
        tbl.push_back(mk(1,1,1,0,1,0, 3'd0, 0, 0, 32'h80, 0,                 32'h13C, 1,0, 3,2));
        tbl.push_back(mk(1,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h140, 0,0, 3,2));
        tbl.push_back(mk(1,0,1,0,1,0, 3'd0, 0, 0, 32'hFFFFFFF8, 0,           32'h138, 1,0, 3,3));
        tbl.push_back(mk(1,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h13C, 0,0, 3,3));
        tbl.push_back(mk(1,0,1,0,0,1, 3'd0, 32'h203, 0, 32'h4, 0,            32'h13C, 1,1, 3,3));
        tbl.push_back(mk(1,0,1,0,1,0, 3'd0, 0, 0, 32'h8, 0,                  32'h13C, 1,1, 3,3));
        tbl.push_back(mk(0,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h100, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,1,1,1, 3'd0, 32'h1000, 0, 32'h80, 1,          32'h180, 1,0, 0,1));
        tbl.push_back(mk(1,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h184, 0,0, 0,1));
        tbl.push_back(mk(1,0,1,1,0,0, 3'd5, 0, 0, 32'h2, 1,                  32'h184, 1,1, 1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h100, 0,0, 0,0));
        tbl.push_back(mk(1,0,1,0,0,1, 3'd0, 32'hFFFFFFF0, 0, 32'h8, 0,       32'hFFFFFFF8, 1,0, 0,1));
        tbl.push_back(mk(1,0,0,0,0,0, 3'd0, 0, 0, 0, 0,                      32'hFFFFFFFC, 0,0, 0,1));
        tbl.push_back(mk(1,0,1,0,0,0, 3'd0, 0, 0, 0, 0,                      32'h000, 0,0, 0,1));
        tbl.push_back(mk(1,0,1,1,0,1, 3'd0, 32'h40, 0, 32'h4, 1,             32'h044, 1,0, 0,2));

        foreach (tbl[i]) begin
            drive(tbl[i].rn, tbl[i].st, tbl[i].v, tbl[i].br, tbl[i].jal, tbl[i].jalr,
                  tbl[i].f3, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].cmp);
            tick();
            chk($sformatf("tbl%0d_pc", i),    pc_a,        tbl[i].e_pc);
            chk($sformatf("tbl%0d_flush", i), 32'(fl_a),   32'(tbl[i].e_fl));
            chk($sformatf("tbl%0d_mis", i),   32'(mis_a),  32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d_bc", i),    32'(bc_a),   32'(tbl[i].e_bc));
            chk($sformatf("tbl%0d_tc", i),    32'(tc_a),   32'(tbl[i].e_tc));
        end

        // five back-to-back taken JALs: the 2-bit counter with no flush window sticks at 3
        drive(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        tick();
        for (int j = 0; j < 5; j++) begin
            drive(1, 0, 1, 0, 1, 0, 3'd0, 0, 0, 32'h8, 0);
            tick();
        end
        chk("sat_tc_b", 32'(tc_b), 32'd3);
        chk("sat_pc_b", pc_b, 32'h128);

        // three-cycle flush window on dut_c
        drive(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 1, 0, 0, 3'd0, 5, 5, 32'h40, 1);
        tick();
        chk("fl3_redirect_pc", pc_c, 32'h140);
        chk("fl3_redirect_fl", 32'(fl_c), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        tick();
        tick();
        chk("fl3_mid_fl", 32'(fl_c), 32'd1);
        tick();
        chk("fl3_end_fl", 32'(fl_c), 32'd0);
        chk("fl3_end_pc", pc_c, 32'h14C);

        // random traffic; occasional resets pull instances out of HALT
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] imm;
            int sel;
            sel = $urandom_range(0, 3);
            imm = 32'($urandom_range(0, 1023) * 4) - 32'd2048;
            if ($urandom_range(0, 31) == 0) imm = imm | 32'($urandom_range(1, 3));
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  sel == 1 || $urandom_range(0, 7) == 0,
                  sel == 2 || $urandom_range(0, 15) == 0,
                  sel == 3 || $urandom_range(0, 15) == 0,
                  3'($urandom_range(0, 7)), $urandom & ~32'h2, $urandom, imm,
                  1'($urandom_range(0, 1)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Sequential program-counter and branch-resolution controller for the single-cycle RV32I core.
- Owns the PC register and drives the operands and funct3 of the existing branch comparator, which sits beside it in the core top.
- Selects next PC for BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR, and inserts a configurable flush window after redirects.
- Detects misaligned targets and keeps saturating branch statistics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 1, bubble cycles after a taken redirect (0..7; 0 = no FLUSH state entered)
COUNT_W, 16, width of statistics counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, synchronous, active-low
stall_i  in  1  global hold; freezes all state
instr_valid_i  in  1  current instruction is valid
is_branch_i  in  1  decoded conditional branch
is_jal_i  in  1  decoded JAL
is_jalr_i  in  1  decoded JALR
funct3_i  in  3  instruction funct3
rs1_data_i  in  32  register rs1 value
rs2_data_i  in  32  register rs2 value
imm_i  in  32  sign-extended immediate (B/J/I type)
cmp_operand_a_o  out  32  to comparator operand A (= rs1_data_i)
cmp_operand_b_o  out  32  to comparator operand B (= rs2_data_i)
cmp_operation_o  out  3  to comparator operation (= funct3_i)
cmp_result_i  in  1  comparator result, combinational same cycle
pc_o  out  32  current PC
flush_o  out  1  squash instruction in flight
misalign_o  out  1  sticky misaligned-target error
branch_count_o  out  COUNT_W  resolved conditional branches
taken_count_o  out  COUNT_W  taken redirects (branches + jumps)

Behaviour:
- Reset (rst_n=0 at a clk edge): pc_o=RESET_PC, state=RUN, flush_o=0, misalign_o=0, both counters=0, flush counter=0.
- Comparator outputs are pure pass-through, driven every cycle regardless of state.
- States: RUN, FLUSH, HALT.
- stall_i=1: no register changes in any state, including the flush counter; outputs hold their values.
- RUN with instr_valid_i=1:
  - Class priority: is_jal_i > is_jalr_i > is_branch_i.
  - JAL: target = pc_o + imm_i; taken.
  - JALR: target = (rs1_data_i + imm_i) & ~32'h1; taken.
  - Branch: legal funct3 in {000,001,100,101,110,111} → branch_count +1; taken = cmp_result_i; target = pc_o + imm_i.
  - Branch with funct3 010/011: treated as not-taken; not counted.
  - Otherwise: next = pc_o + 4 (32-bit wrap: 32'hFFFF_FFFC → 0).
  - Taken and target[1:0]!=0: pc_o holds, misalign_o=1, go to HALT; taken_count not incremented.
  - Taken and aligned: pc_o <= target, taken_count +1.
    - FLUSH_CYCLES>0: go to FLUSH and load flush counter = FLUSH_CYCLES.
    - FLUSH_CYCLES=0: stay in RUN.
- RUN with instr_valid_i=0: pc_o holds; no count.
- FLUSH:
  - flush_o=1 (registered, asserted from the cycle after the redirect edge).
  - Inputs ignored; pc_o advances by +4 each cycle so fetch continues; counter decrements.
  - At counter==1, next state is RUN and flush_o drops the following cycle.
- HALT: pc_o frozen; misalign_o=1; flush_o=1; left only via reset.
- Counters saturate at all-ones (no wrap); both increment in the same cycle for a taken legal branch.
- Reset asserted in FLUSH or HALT takes priority over every other event and returns to the reset values above.
- Latency: next-PC decision is visible on pc_o one cycle after the instruction is presented.

Decomposition:
- Package branch_pkg:
  - funct3 constants BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111.
  - Enum state_t {RUN, FLUSH, HALT}.
  - Constant PC_STEP=32'd4.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, en, count), instantiated twice.
- The comparator stays a separate sibling instance in the core top; it is not instantiated inside this block.

Test Plan:
- Reset with RESET_PC=32'h100 → pc_o=0x100, all outputs 0; 3 cycles of non-branch valid instructions → pc_o=0x10C.
- BEQ with rs1=rs2=0xABCDEFFF, imm=0x20, pc=0x100, comparator returns 1 → pc_o=0x120, flush_o=1 for exactly 1 cycle, branch_count=1, taken_count=1.
- BLT with rs1=0xABCDEF01, rs2=0x12345678, cmp_operation_o=100, cmp_result_i=0 forced → pc_o=pc+4, branch_count+1, taken_count unchanged.
- JALR with rs1=0x203, imm=0x4 → pc_o=0x206 is misaligned → HALT, misalign_o=1, pc_o frozen; rst_n=0 for one edge → pc_o=RESET_PC, misalign_o=0.
- Taken branch followed by stall_i=1 for 3 cycles during FLUSH → flush_o stays 1 and pc_o frozen for those 3 cycles; after release, flush completes normally.
- COUNT_W=2 with 5 taken JALs → taken_count saturates at 3; funct3=010 with is_branch_i=1 → not taken, branch_count unchanged.
